// File: rtl/id_stage.sv
// id_stage: RV32I decode stage; one output pipeline register between fetch and execute.
// Latency: 1 cycle from acceptance to out_valid_o; 1 instruction/cycle without hazards.
// Backpressure: holds its output while out_ready_i=0; inserts one bubble on a load-use hazard.
//
// Ports: clk/rst (sync, active-high); flush_i; fetch side in_valid_i/in_ready_o/ins_i/ins_addr_i;
// execute side out_valid_o/out_ready_i plus registered ins_o, ins_addr_o, rs1/rs2/rd_addr_o,
// rd_we_o, imm_o, is_load_o, illegal_o.
// Optional feature: define ID_RV32E_EN to flag any used register field >= x16 as illegal.
module id_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     ins_i,
    input  logic [PC_W-1:0] ins_addr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     ins_o,
    output logic [PC_W-1:0] ins_addr_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] imm_o,
    output logic            is_load_o,
    output logic            illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Combinational decode of the incoming word
    logic            use_rs1, use_rs2, use_rd;
    logic            known, load_raw, illegal_d;
    logic [31:0]     imm32;
    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            dec_we, dec_load;
    logic [XLEN-1:0] dec_imm;

    always_comb begin
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        load_raw = 1'b0;
        known    = 1'b1;
        imm32    = '0;
        case (ins_i[6:0])
            OP_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OP_IMM, OP_JALR, OP_LOAD: begin
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                load_raw = (ins_i[6:0] == OP_LOAD);
                imm32    = {{20{ins_i[31]}}, ins_i[31:20]};
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
            end
            OP_JAL: begin
                use_rd = 1'b1;
                imm32  = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                use_rd = 1'b1;
                imm32  = {ins_i[31:12], 12'b0};
            end
            default: known = 1'b0;
        endcase

        illegal_d = ~known;
`ifdef ID_RV32E_EN
        // RV32E has only x0..x15: bit 4 of any used register field is out of range
        if ((use_rs1 & ins_i[19]) | (use_rs2 & ins_i[24]) | (use_rd & ins_i[11]))
            illegal_d = 1'b1;
`endif

        // Illegal words present as all-zero fields so downstream sees no side effects
        dec_rs1  = (use_rs1 & ~illegal_d) ? ins_i[19:15] : 5'd0;
        dec_rs2  = (use_rs2 & ~illegal_d) ? ins_i[24:20] : 5'd0;
        dec_rd   = (use_rd  & ~illegal_d) ? ins_i[11:7]  : 5'd0;
        dec_we   = use_rd & ~illegal_d & (ins_i[11:7] != 5'd0);
        dec_load = load_raw & ~illegal_d;
        dec_imm  = illegal_d ? '0 : XLEN'($signed(imm32));
    end

    // Unused sources decode to 0 and a hazard needs rd_addr_o != 0, so comparing the
    // decoded addresses only ever matches sources the incoming format really reads.
    logic hazard, advance;

    assign hazard  = out_valid_o & is_load_o & (rd_addr_o != 5'd0) & in_valid_i &
                     ((dec_rs1 == rd_addr_o) | (dec_rs2 == rd_addr_o));
    assign advance = ~out_valid_o | out_ready_i;
    assign in_ready_o = flush_i | (advance & ~hazard);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            ins_o       <= '0;
            ins_addr_o  <= '0;
            rs1_addr_o  <= '0;
            rs2_addr_o  <= '0;
            rd_addr_o   <= '0;
            rd_we_o     <= 1'b0;
            imm_o       <= '0;
            is_load_o   <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            // Incoming word is consumed (in_ready_o=1) but dropped
            out_valid_o <= 1'b0;
        end else if (advance) begin
            if (in_valid_i & in_ready_o) begin
                out_valid_o <= 1'b1;
                ins_o       <= ins_i;
                ins_addr_o  <= ins_addr_i;
                rs1_addr_o  <= dec_rs1;
                rs2_addr_o  <= dec_rs2;
                rd_addr_o   <= dec_rd;
                rd_we_o     <= dec_we;
                imm_o       <= dec_imm;
                is_load_o   <= dec_load;
                illegal_o   <= illegal_d;
            end else begin
                // Idle or load-use bubble; payload fields keep their last value
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] ins_i = '0;
    logic [31:0] ins_addr_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] ins_o;
    logic [31:0] ins_addr_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic        rd_we_o;
    logic [31:0] imm_o;
    logic        is_load_o;
    logic        illegal_o;

    id_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .ins_o(ins_o), .ins_addr_o(ins_addr_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .rd_we_o(rd_we_o), .imm_o(imm_o), .is_load_o(is_load_o), .illegal_o(illegal_o)
    );

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        we;
        logic [31:0] imm;
        logic        load;
        logic        ill;
    } dec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the output register should hold
    logic        m_init  = 1'b0;
    logic        m_vld   = 1'b0;
    logic        m_known = 1'b0;
    dec_t        m_d;
    logic [31:0] m_ins, m_addr;
    logic        last_rdy;

    // Decode from the ISA's field definitions using integer arithmetic
    function automatic dec_t ref_dec(input logic [31:0] w);
        dec_t d;
        int unsigned op;
        bit u1, u2, ud, ld, ok;
        logic signed [31:0] s;
        int top20, top25, sgn;
        int imm;
        s     = w;
        top20 = s >>> 20;
        top25 = s >>> 25;
        sgn   = s >>> 31;
        op = w % 128;
        u1 = 0; u2 = 0; ud = 0; ld = 0; ok = 1; imm = 0;
        if (op == 'h33) begin u1 = 1; u2 = 1; ud = 1; end
        else if (op == 'h13 || op == 'h67) begin u1 = 1; ud = 1; imm = top20; end
        else if (op == 'h03) begin u1 = 1; ud = 1; ld = 1; imm = top20; end
        else if (op == 'h23) begin u1 = 1; u2 = 1; imm = top25 * 32 + int'((w / 128) % 32); end
        else if (op == 'h63) begin
            u1 = 1; u2 = 1;
            imm = sgn * 4096 + int'((w / 128) % 2) * 2048 + int'((w / (1 << 25)) % 64) * 32
                + int'((w / 256) % 16) * 2;
        end
        else if (op == 'h6F) begin
            ud = 1;
            imm = sgn * (1 << 20) + int'((w / 4096) % 256) * 4096 + int'((w / (1 << 20)) % 2) * 2048
                + int'((w / (1 << 21)) % 1024) * 2;
        end
        else if (op == 'h37 || op == 'h17) begin ud = 1; imm = int'(w & 32'hFFFFF000); end
        else ok = 0;
        d.ill = !ok;
`ifdef ID_RV32E_EN
        if ((u1 && ((w / (1 << 15)) % 32) >= 16) || (u2 && ((w / (1 << 20)) % 32) >= 16) ||
            (ud && ((w / 128) % 32) >= 16))
            d.ill = 1;
`endif
        d.rs1  = (u1 && !d.ill) ? 5'((w / (1 << 15)) % 32) : 5'd0;
        d.rs2  = (u2 && !d.ill) ? 5'((w / (1 << 20)) % 32) : 5'd0;
        d.rd   = (ud && !d.ill) ? 5'((w / 128) % 32) : 5'd0;
        d.we   = ud && !d.ill && d.rd != 0;
        d.load = ld && !d.ill;
        d.imm  = d.ill ? 32'd0 : 32'(imm);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        if (!m_init) return;
        chk("out_valid", out_valid_o, m_vld);
        if (m_known) begin
            chk("ins_o", ins_o, m_ins);
            chk("ins_addr_o", ins_addr_o, m_addr);
            chk("rs1", rs1_addr_o, m_d.rs1);
            chk("rs2", rs2_addr_o, m_d.rs2);
            chk("rd", rd_addr_o, m_d.rd);
            chk("rd_we", rd_we_o, m_d.we);
            chk("imm", imm_o, m_d.imm);
            chk("is_load", is_load_o, m_d.load);
            chk("illegal", illegal_o, m_d.ill);
        end
    endtask

    // One clock: drive at negedge, check ready and held outputs, advance model at posedge
    task automatic step(input logic r, input logic f, input logic v, input logic [31:0] w,
                        input logic [31:0] a, input logic ordy);
        dec_t d;
        logic src_hit, hz, erdy;
        @(negedge clk);
        rst = r; flush_i = f; in_valid_i = v; ins_i = w; ins_addr_i = a; out_ready_i = ordy;
        #1;
        d = ref_dec(w);
        src_hit = (d.rs1 == m_d.rd) || (d.rs2 == m_d.rd);
        hz   = m_vld && m_d.load && (m_d.rd != 0) && v && src_hit;
        erdy = f || ((!m_vld || ordy) && !hz);
        last_rdy = in_ready_o;
        if (m_init) chk("in_ready", in_ready_o, erdy);
        check_outputs();
        @(posedge clk);
        if (r) begin
            m_init = 1; m_vld = 0; m_known = 1;
            m_d = '{5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0};
            m_ins = 0; m_addr = 0;
        end else if (f) begin
            m_vld = 0; m_known = 0;
        end else if (!m_vld || ordy) begin
            if (v && erdy) begin
                m_vld = 1; m_known = 1; m_d = d; m_ins = w; m_addr = a;
            end else begin
                m_vld = 0; m_known = 0;
            end
        end
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        logic [4:0] r;
        r = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) r = r + 5'd16;
        return r;
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [6:0]  ops [10];
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h0B};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 9)];
        w[19:15] = pick_reg();
        w[24:20] = pick_reg();
        w[11:7]  = pick_reg();
        return w;
    endfunction

    localparam logic [31:0] ADDI = 32'hFFF10093;
    localparam logic [31:0] LW   = 32'h0080A283;
    localparam logic [31:0] ADD  = 32'h00528333;
    localparam logic [31:0] BEQ  = 32'hFE208EE3;
    localparam logic [31:0] ADD16 = 32'h00208833;

    initial begin
        // Reset state
        step(1, 0, 0, 0, 0, 0);
        chk("rst_valid", out_valid_o, 0);
        chk("rst_illegal", illegal_o, 0);
        chk("rst_ins", ins_o, 0);
        chk("rst_rd", rd_addr_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_we", rd_we_o, 0);

        // addi x1,x2,-1
        step(0, 0, 1, ADDI, 32'h100, 1);
        chk("addi_valid", out_valid_o, 1);
        chk("addi_rs1", rs1_addr_o, 2);
        chk("addi_rs2", rs2_addr_o, 0);
        chk("addi_rd", rd_addr_o, 1);
        chk("addi_we", rd_we_o, 1);
        chk("addi_imm", imm_o, 32'hFFFFFFFF);

        // lw x5,8(x1) then dependent add: one bubble
        step(0, 0, 1, LW, 32'h104, 1);
        chk("lw_load", is_load_o, 1);
        chk("lw_imm", imm_o, 8);
        step(0, 0, 1, ADD, 32'h108, 1);
        chk("hazard_rdy", last_rdy, 0);
        chk("bubble", out_valid_o, 0);
        step(0, 0, 1, ADD, 32'h108, 1);
        chk("post_bubble_rdy", last_rdy, 1);
        chk("add_valid", out_valid_o, 1);
        chk("add_rs1", rs1_addr_o, 5);
        chk("add_rs2", rs2_addr_o, 5);
        chk("add_rd", rd_addr_o, 6);

        // beq held for 3 stall cycles
        step(0, 0, 1, BEQ, 32'h10C, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, ADDI, 32'h110, 0);
            chk("stall_rdy", last_rdy, 0);
            chk("stall_valid", out_valid_o, 1);
            chk("beq_imm", imm_o, 32'hFFFFFFFC);
            chk("beq_rs1", rs1_addr_o, 1);
            chk("beq_rs2", rs2_addr_o, 2);
            chk("beq_we", rd_we_o, 0);
            chk("beq_ins", ins_o, BEQ);
        end

        // Flush while stalled with a new word presented
        step(0, 1, 1, LW, 32'h114, 0);
        chk("flush_rdy", last_rdy, 1);
        chk("flush_valid", out_valid_o, 0);
        step(0, 0, 1, ADDI, 32'h118, 1);
        chk("post_flush_valid", out_valid_o, 1);
        chk("post_flush_rd", rd_addr_o, 1);

        // add x16,x1,x2
        step(0, 0, 1, ADD16, 32'h11C, 1);
`ifdef ID_RV32E_EN
        chk("x16_illegal", illegal_o, 1);
        chk("x16_rd", rd_addr_o, 0);
`else
        chk("x16_illegal", illegal_o, 0);
        chk("x16_rd", rd_addr_o, 16);
        chk("x16_we", rd_we_o, 1);
`endif

        // All-zero word is illegal, then reset mid-stream
        step(0, 0, 1, 32'h0, 32'h120, 1);
        chk("zero_illegal", illegal_o, 1);
        chk("zero_imm", imm_o, 0);
        step(0, 0, 1, ADDI, 32'h124, 0);
        step(1, 1, 1, ADDI, 32'h128, 0);
        chk("rst2_valid", out_valid_o, 0);
        chk("rst2_ins", ins_o, 0);
        chk("rst2_addr", ins_addr_o, 0);
        chk("rst2_illegal", illegal_o, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) != 0, rand_ins(), $urandom,
                 $urandom_range(0, 3) != 0);
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
